uart_frame_checker: RTL
=======================

# uart_frame_checker

Parametrised UART receive-frame checker that sits behind the bit sampler and ahead of the RX FIFO. It consumes mid-bit sample strobes and runs a start/data/parity/stop state machine. Configurable frames are delivered over a valid/ready handshake through a single-entry holding register. Parity errors, framing errors, breaks and overruns are flagged.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY_MODE, 2, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits checked, legal 1..2

Ports:
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- rx_in  in  1  synchronised serial line, idle high
- bit_tick  in  1  one-cycle strobe at each mid-bit sample point; rx_in is sampled only when bit_tick = 1
- data_ready  in  1  consumer accepts data_out when data_valid & data_ready
- data_out  out  DATA_BITS  received word, LSB = first data bit; reset 0
- data_valid  out  1  holding register full; reset 0
- parity_err  out  1  one-cycle pulse, parity mismatch; reset 0
- frame_err  out  1  one-cycle pulse, a stop bit sampled low; reset 0
- break_det  out  1  one-cycle pulse, all data bits, parity bit and stop bits low; reset 0
- overrun  out  1  one-cycle pulse, good frame dropped because holding register occupied; reset 0

## Operation
- States: IDLE, DATA, PARITY, STOP, WAIT_IDLE. Only transitions on cycles with bit_tick = 1; otherwise state, counters and shift register hold.
- IDLE: on tick with rx_in = 0, treat the sample as the start bit, clear bit_cnt, go to DATA. A tick with rx_in = 1 keeps IDLE.
- DATA: on each tick, shift rx_in into shift register (LSB first) and increment bit_cnt. After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: on tick, capture the parity bit. Expected value is XOR of data bits for even mode and its inverse for odd mode. Go to STOP.
- STOP: on each tick, check rx_in, accumulating stop_low if any sample is 0. After STOP_BITS samples, commit (below), then go to IDLE if the last sample was 1, else to WAIT_IDLE.
- WAIT_IDLE: stay until a tick samples rx_in = 1, then go to IDLE. This prevents a held-low line (break) from re-triggering as a start bit.
- Commit, in the cycle of the final stop tick:
  - good = no parity error and no stop_low.
  - good & (!data_valid | data_ready): data_out <= shift register, data_valid <= 1.
  - good & data_valid & !data_ready: new word discarded, old data_out kept, overrun pulses.
  - Parity error: parity_err pulses and the word is discarded.
  - stop_low: frame_err pulses and the word is discarded.
  - Both errors: both pulse.
  - break_det pulses with frame_err when the shift register is 0, the parity bit (if present) is 0 and every stop sample is 0.
- Handshake: data_valid clears on data_valid & data_ready unless a good commit occurs in the same cycle. In that case data_out is replaced and data_valid stays 1, with no overrun.
- Reset mid-frame: asynchronous return to IDLE, all outputs 0, partial frame lost.

## Timing
- All outputs are registered. data_valid, data_out and the error pulses update on the clock edge where the final stop-bit tick is high, so they are visible the next cycle.
- Frame latency: 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS ticks from start sample to commit.
- Pulse outputs are high for exactly one clk cycle regardless of tick spacing.
- data_out is stable while data_valid = 1 and no accept occurs.
- Back-to-back ticks (bit_tick held high) are legal; one bit is consumed per cycle.

## Structure
- Shared package uart_pkg:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN
  - state enum checker_state_t (IDLE, DATA, PARITY, STOP, WAIT_IDLE)
  - elaboration-time legality checks for DATA_BITS and STOP_BITS
- Single module; no sub-module needed. Parity is a reduction XOR inline.

## Test plan
- Defaults (8/even/1), send 0xA5 with parity 0 and stop 1, ready held 1 → data_out = 0xA5, data_valid high one cycle, no error pulses.
- Send 0x3C with parity bit 1 (wrong) → parity_err one pulse, data_valid stays 0, data_out unchanged.
- Send 0x55 with stop bit 0 then line high → frame_err pulse, no data_valid; FSM passes WAIT_IDLE to IDLE on next high tick.
- Hold line low 12 ticks → frame_err and break_det pulse together; no second frame until rx_in returns high, then 0x12 is received correctly.
- data_ready = 0, send 0x11 then 0x22 → data_out = 0x11 kept, overrun pulses at the second commit. Repeat with data_ready = 1 on the commit cycle → data_out = 0x22, data_valid stays 1, no overrun.
- DATA_BITS = 7, PARITY_MODE = 0, STOP_BITS = 2: send 0x7F with second stop bit 0 → frame_err. Assert reset mid-DATA → all outputs 0 immediately and the next frame decodes cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: parity mode encodings, the
// frame-checker state enum and elaboration-time legality helpers for the
// frame-format parameters.
package uart_pkg;

  // Parity mode encodings (PARITY_MODE parameter values)
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Frame checker states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } checker_state_t;

  // Legal data-bit count per frame
  function automatic bit data_bits_legal(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  // Legal number of checked stop bits
  function automatic bit stop_bits_legal(input int n);
    return (n >= 1) && (n <= 2);
  endfunction

  // Legal parity mode selector
  function automatic bit parity_mode_legal(input int m);
    return (m >= 0) && (m <= 2);
  endfunction

endpackage

// File: rtl/uart_frame_checker.sv
// uart_frame_checker
// Consumes mid-bit samples of a synchronised RX line and checks
// start/data/parity/stop framing. Good words are delivered through a
// single-entry holding register with a valid/ready handshake; parity errors,
// framing errors, breaks and overruns are reported as one-cycle pulses.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low; clears all state and outputs
//   rx_in      - synchronised serial line, idle high
//   bit_tick   - one-cycle strobe at each mid-bit sample point
//   data_ready - consumer accepts data_out when data_valid & data_ready
//   data_out   - received word, LSB = first data bit
//   data_valid - holding register full
//   parity_err - pulse: parity mismatch
//   frame_err  - pulse: a stop bit sampled low
//   break_det  - pulse: data, parity and stop bits all low
//   overrun    - pulse: good frame dropped, holding register occupied
module uart_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 bit_tick,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  // Reject illegal frame formats at elaboration
  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_frame_checker: DATA_BITS must be 5..9");
  end
  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_frame_checker: STOP_BITS must be 1..2");
  end
  if (!parity_mode_legal(PARITY_MODE)) begin : g_bad_parity_mode
    $error("uart_frame_checker: PARITY_MODE must be 0..2");
  end

  localparam logic [1:0] PMODE     = 2'(PARITY_MODE);
  localparam logic       HAS_PAR   = (PMODE != PAR_NONE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  checker_state_t       r_state, w_state;
  logic [3:0]           r_bit_cnt, w_bit_cnt;
  logic [1:0]           r_stop_cnt, w_stop_cnt;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_par_bit, w_par_bit;
  logic                 r_stop_low, w_stop_low;
  logic                 r_stop_high, w_stop_high;
  logic [DATA_BITS-1:0] r_data_out, w_data_out;
  logic                 r_data_valid, w_data_valid;
  logic                 r_parity_err, w_parity_err;
  logic                 r_frame_err, w_frame_err;
  logic                 r_break_det, w_break_det;
  logic                 r_overrun, w_overrun;

  logic w_par_exp;
  logic w_par_bad;
  logic w_stop_low_fin;
  logic w_stop_high_fin;
  logic w_good;

  // Frame verdict, evaluated against the current stop sample so the commit
  // can happen in the same cycle as the final stop tick.
  assign w_par_exp       = (PMODE == PAR_ODD) ? ~(^r_shift) : (^r_shift);
  assign w_par_bad       = HAS_PAR & (r_par_bit != w_par_exp);
  assign w_stop_low_fin  = r_stop_low | ~rx_in;
  assign w_stop_high_fin = r_stop_high | rx_in;
  assign w_good          = ~w_par_bad & ~w_stop_low_fin;

  // Next-state, datapath and output computation
  always_comb begin
    w_state      = r_state;
    w_bit_cnt    = r_bit_cnt;
    w_stop_cnt   = r_stop_cnt;
    w_shift      = r_shift;
    w_par_bit    = r_par_bit;
    w_stop_low   = r_stop_low;
    w_stop_high  = r_stop_high;
    w_data_out   = r_data_out;
    // A pending word is released on accept unless a good commit refills it.
    w_data_valid = r_data_valid & ~data_ready;
    w_parity_err = 1'b0;
    w_frame_err  = 1'b0;
    w_break_det  = 1'b0;
    w_overrun    = 1'b0;

    if (bit_tick) begin
      case (r_state)
        IDLE: begin
          if (!rx_in) begin
            w_state     = DATA;
            w_bit_cnt   = 4'd0;
            w_stop_cnt  = 2'd0;
            w_par_bit   = 1'b0;
            w_stop_low  = 1'b0;
            w_stop_high = 1'b0;
          end else begin
            w_state = IDLE;
          end
        end
        DATA: begin
          w_shift   = {rx_in, r_shift[DATA_BITS-1:1]};
          w_bit_cnt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == LAST_DATA) begin
            w_state = HAS_PAR ? PARITY : STOP;
          end else begin
            w_state = DATA;
          end
        end
        PARITY: begin
          w_par_bit = rx_in;
          w_state   = STOP;
        end
        STOP: begin
          w_stop_low  = w_stop_low_fin;
          w_stop_high = w_stop_high_fin;
          w_stop_cnt  = r_stop_cnt + 2'd1;
          if (r_stop_cnt == LAST_STOP) begin
            if (w_good) begin
              if (!r_data_valid || data_ready) begin
                w_data_out   = r_shift;
                w_data_valid = 1'b1;
              end else begin
                w_overrun = 1'b1;
              end
            end else begin
              w_parity_err = w_par_bad;
              w_frame_err  = w_stop_low_fin;
              w_break_det  = w_stop_low_fin & ~w_stop_high_fin &
                             (r_shift == '0) & ~(HAS_PAR & r_par_bit);
            end
            // A low final stop sample means the line may be held in break;
            // wait for it to go high before hunting for a start bit.
            w_state = rx_in ? IDLE : WAIT_IDLE;
          end else begin
            w_state = STOP;
          end
        end
        WAIT_IDLE: begin
          if (rx_in) begin
            w_state = IDLE;
          end else begin
            w_state = WAIT_IDLE;
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end else begin
      w_state = r_state;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_stop_cnt   <= 2'd0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop_low   <= 1'b0;
      r_stop_high  <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break_det  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bit_cnt    <= w_bit_cnt;
      r_stop_cnt   <= w_stop_cnt;
      r_shift      <= w_shift;
      r_par_bit    <= w_par_bit;
      r_stop_low   <= w_stop_low;
      r_stop_high  <= w_stop_high;
      r_data_out   <= w_data_out;
      r_data_valid <= w_data_valid;
      r_parity_err <= w_parity_err;
      r_frame_err  <= w_frame_err;
      r_break_det  <= w_break_det;
      r_overrun    <= w_overrun;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign break_det  = r_break_det;
  assign overrun    = r_overrun;

endmodule
